// File: rtl/apb3_cmd_requester_if.sv
// Bundle of the command, response, APB3 and wait-counter signals of apb3_cmd_requester.
// The master modport is the requester's view; slave is the view of whatever drives it.
interface apb3_cmd_requester_if #(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32,
  parameter int WaitCntWidth = 16
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [AddressWidth-1:0] cmd_addr;
  logic [DataWidth-1:0]    cmd_wdata;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DataWidth-1:0]    rsp_rdata;
  logic                    rsp_slverr;
  logic                    rsp_timeout;
  logic [AddressWidth-1:0] paddr;
  logic                    pselx;
  logic                    penable;
  logic                    pwrite;
  logic [DataWidth-1:0]    pwdata;
  logic                    pready;
  logic [DataWidth-1:0]    prdata;
  logic                    pslverr;
  logic [WaitCntWidth-1:0] wait_cycles;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output paddr, pselx, penable, pwrite, pwdata, wait_cycles
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  paddr, pselx, penable, pwrite, pwdata, wait_cycles
  );
endinterface

// File: rtl/apb3_cmd_requester.sv
// APB3 requester: one transfer in flight, valid/ready command and response channels.
// Optional wait-state abort is enabled by defining APB3_REQ_TIMEOUT_EN.
module apb3_cmd_requester #(
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int WaitCntWidth  = 16,
  parameter int TimeoutCycles = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  apb3_cmd_requester_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state_q;
  logic [AddressWidth-1:0] paddr_q;
  logic [DataWidth-1:0]    pwdata_q;
  logic                    pwrite_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    rsp_valid_q;
  logic [DataWidth-1:0]    rsp_rdata_q;
  logic                    rsp_slverr_q;
  logic                    rsp_timeout_q;
  logic [WaitCntWidth-1:0] wait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            pwrite_q <= bus.cmd_write;
            paddr_q  <= bus.cmd_addr;
            pwdata_q <= bus.cmd_wdata;
            wait_q   <= '0;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            // Writes return zero so an undriven PRDATA never reaches the response.
            rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
            rsp_slverr_q  <= bus.pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end
`ifdef APB3_REQ_TIMEOUT_EN
          else if (wait_q == WaitCntWidth'(TimeoutCycles)) begin
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end
`endif
          else if (wait_q != '1) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE) && rst_n;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pselx       = psel_q;
  assign bus.penable     = penable_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_slverr  = rsp_slverr_q;
  assign bus.wait_cycles = wait_q;
`ifdef APB3_REQ_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_timeout_q;
`else
  // Without the abort path the timeout flag can never be set; keep the register unobserved.
  assign bus.rsp_timeout = 1'b0;
  logic unused_timeout;
  assign unused_timeout = rsp_timeout_q;
`endif

endmodule

// File: tb/tb_apb3_cmd_requester.sv
// Directed bench for apb3_cmd_requester: latency, wait states, errors, backpressure,
// timeout (or indefinite wait without APB3_REQ_TIMEOUT_EN) and reset mid-transfer.
module tb_apb3_cmd_requester;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  apb3_cmd_requester_if #(.AddressWidth(20), .DataWidth(32), .WaitCntWidth(16)) bus ();

  apb3_cmd_requester #(
    .AddressWidth (20),
    .DataWidth    (32),
    .WaitCntWidth (16),
    .TimeoutCycles(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit stayed;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    bus.pslverr   = 1'b0;

    // Reset state
    #12;
    chk("rst_psel", bus.pselx, 1'b0);
    chk("rst_pen", bus.penable, 1'b0);
    chk("rst_paddr", bus.paddr, 20'h0);
    chk("rst_pwdata", bus.pwdata, 32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_wait", bus.wait_cycles, 16'h0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    rst_n = 1'b1;
    step();
    chk("idle_cmd_ready", bus.cmd_ready, 1'b1);

    // Write, zero wait; PRDATA is X to prove it does not leak into rsp_rdata
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 20'h00010;
    bus.cmd_wdata = 32'hDEADBEEF;
    bus.pready    = 1'b1;
    bus.prdata    = 'x;
    step();
    bus.cmd_valid = 1'b0;
    chk("wr_setup_psel", bus.pselx, 1'b1);
    chk("wr_setup_pen", bus.penable, 1'b0);
    chk("wr_setup_cmd_ready", bus.cmd_ready, 1'b0);
    step();
    chk("wr_access_psel", bus.pselx, 1'b1);
    chk("wr_access_pen", bus.penable, 1'b1);
    chk("wr_access_paddr", bus.paddr, 20'h00010);
    chk("wr_access_pwdata", bus.pwdata, 32'hDEADBEEF);
    chk("wr_access_pwrite", bus.pwrite, 1'b1);
    step();
    chk("wr_rsp_valid", bus.rsp_valid, 1'b1);
    chk("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("wr_rsp_slverr", bus.rsp_slverr, 1'b0);
    chk("wr_rsp_timeout", bus.rsp_timeout, 1'b0);
    chk("wr_wait", bus.wait_cycles, 16'd0);
    chk("wr_resp_psel", bus.pselx, 1'b0);
    bus.rsp_ready = 1'b1;
    bus.prdata    = '0;
    step();
    bus.rsp_ready = 1'b0;
    chk("wr_done_rsp_valid", bus.rsp_valid, 1'b0);
    chk("wr_done_cmd_ready", bus.cmd_ready, 1'b1);

    // Read with 3 wait states
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 20'h00ABC;
    bus.pready    = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_psel", bus.pselx, 1'b1);
      chk("rd_wait_pen", bus.penable, 1'b1);
      chk("rd_wait_paddr", bus.paddr, 20'h00ABC);
      chk("rd_wait_count", bus.wait_cycles, 16'(i));
      chk("rd_wait_rsp_valid", bus.rsp_valid, 1'b0);
      step();
    end
    bus.pready = 1'b1;
    bus.prdata = 32'h12345678;
    chk("rd_last_psel", bus.pselx, 1'b1);
    chk("rd_last_pen", bus.penable, 1'b1);
    chk("rd_last_paddr", bus.paddr, 20'h00ABC);
    step();
    bus.prdata = 32'hFFFF0000;
    chk("rd_rsp_valid", bus.rsp_valid, 1'b1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'h12345678);
    chk("rd_wait_final", bus.wait_cycles, 16'd3);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rd_hold_wait", bus.wait_cycles, 16'd3);

    // Slave error on a read
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 20'h00200;
    bus.pslverr   = 1'b1;
    bus.prdata    = 32'hCAFE0001;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    bus.pslverr = 1'b0;
    chk("err_rsp_valid", bus.rsp_valid, 1'b1);
    chk("err_slverr", bus.rsp_slverr, 1'b1);
    chk("err_timeout", bus.rsp_timeout, 1'b0);
    chk("err_rdata", bus.rsp_rdata, 32'hCAFE0001);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Response backpressure with cmd_valid held high
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 20'h00003;
    bus.cmd_wdata = 32'h0000A5A5;
    step();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("bp_rsp_slverr", bus.rsp_slverr, 1'b0);
      chk("bp_cmd_ready", bus.cmd_ready, 1'b0);
      chk("bp_psel", bus.pselx, 1'b0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("bp_idle_cmd_ready", bus.cmd_ready, 1'b1);
    chk("bp_idle_rsp_valid", bus.rsp_valid, 1'b0);
    chk("bp_idle_psel", bus.pselx, 1'b0);
    bus.cmd_addr  = 20'h00044;
    bus.cmd_wdata = 32'h00000044;
    step();
    bus.cmd_valid = 1'b0;
    chk("bp_next_psel", bus.pselx, 1'b1);
    chk("bp_next_paddr", bus.paddr, 20'h00044);
    chk("bp_next_pwdata", bus.pwdata, 32'h00000044);
    step();
    step();
    chk("bp_next_rsp_valid", bus.rsp_valid, 1'b1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Timeout behaviour
    bus.pready    = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 20'h00F00;
    step();
    bus.cmd_valid = 1'b0;
    step();
`ifdef APB3_REQ_TIMEOUT_EN
    step();
    step();
    step();
    step();
    chk("to_still_access", bus.penable, 1'b1);
    chk("to_wait4", bus.wait_cycles, 16'd4);
    chk("to_no_rsp_yet", bus.rsp_valid, 1'b0);
    step();
    chk("to_rsp_valid", bus.rsp_valid, 1'b1);
    chk("to_slverr", bus.rsp_slverr, 1'b1);
    chk("to_timeout", bus.rsp_timeout, 1'b1);
    chk("to_rdata", bus.rsp_rdata, 32'h0);
    chk("to_psel", bus.pselx, 1'b0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
`else
    stayed = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (bus.rsp_valid !== 1'b0 || bus.penable !== 1'b1 || bus.pselx !== 1'b1) stayed = 1'b0;
      step();
    end
    chk("nto_stayed_access", stayed, 1'b1);
    chk("nto_rsp_valid", bus.rsp_valid, 1'b0);
    chk("nto_wait_count", bus.wait_cycles, 16'd1000);
`endif

    // Reset during a wait state
    chk("rr_in_access", bus.penable, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_psel", bus.pselx, 1'b0);
    chk("rr_pen", bus.penable, 1'b0);
    chk("rr_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rr_wait", bus.wait_cycles, 16'h0);
    bus.pready = 1'b1;
    #2;
    rst_n = 1'b1;
    step();
    chk("rr_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rr_no_rsp", bus.rsp_valid, 1'b0);
    step();
    chk("rr_no_rsp_later", bus.rsp_valid, 1'b0);
    chk("rr_bus_idle", bus.pselx, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
